// File: rtl/gouram_trace_arbiter.sv
// Round-robin arbiter sharing one trace sink between several gouram tracers.
// One-entry slot per source, registered valid/ready output, saturating drop count.
module gouram_trace_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int TRACE_WIDTH = 128,
  parameter int CNT_WIDTH   = 16,
  localparam int SRC_W      = $clog2(NUM_SRC)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable_i,
  input  logic [NUM_SRC-1:0]             src_valid_i,
  input  logic [NUM_SRC*TRACE_WIDTH-1:0] src_data_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [TRACE_WIDTH-1:0]         out_data_o,
  output logic [SRC_W-1:0]               out_src_o,
  output logic [NUM_SRC-1:0]             overflow_o,
  output logic [CNT_WIDTH-1:0]           drop_count_o,
  input  logic                           clear_i
);

  localparam int SW = CNT_WIDTH + SRC_W + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [NUM_SRC-1:0]     slot_full;
  logic [TRACE_WIDTH-1:0] slot_data [NUM_SRC];
  logic [SRC_W-1:0]       last_grant;

  logic                   free;
  logic                   gnt_valid;
  logic [SRC_W-1:0]       gnt_idx;
  int                     cand;

  logic [NUM_SRC-1:0]     cap;
  logic [NUM_SRC-1:0]     drop;
  logic [SRC_W:0]         drop_num;
  logic [CNT_WIDTH-1:0]   cnt_base;
  logic [SW-1:0]          cnt_sum;
  logic [CNT_WIDTH-1:0]   cnt_nxt;

  assign free = !out_valid_o || out_ready_i;

  // First full slot after last_grant, wrapping to 0.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = (int'(last_grant) + i) % NUM_SRC;
      if (free && !gnt_valid && slot_full[SRC_W'(cand)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SRC_W'(cand);
      end
    end
  end

  // A slot being granted this edge may be refilled at the same edge.
  always_comb begin
    cap      = '0;
    drop     = '0;
    drop_num = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (enable_i && src_valid_i[k]) begin
        if (!slot_full[k] || (gnt_valid && gnt_idx == SRC_W'(k)))
          cap[k] = 1'b1;
        else
          drop[k] = 1'b1;
      end
      drop_num = drop_num + {{SRC_W{1'b0}}, drop[k]};
    end
  end

  always_comb begin
    cnt_base = clear_i ? '0 : drop_count_o;
    cnt_sum  = SW'(cnt_base) + SW'(drop_num);
    cnt_nxt  = (cnt_sum > SW'(CNT_MAX)) ? CNT_MAX
                                        : cnt_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full <= '0;
      for (int k = 0; k < NUM_SRC; k++)
        slot_data[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (cap[k]) begin
          slot_full[k] <= 1'b1;
          slot_data[k] <= src_data_i[k*TRACE_WIDTH +: TRACE_WIDTH];
        end else if (gnt_valid && gnt_idx == SRC_W'(k)) begin
          slot_full[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_src_o   <= '0;
      last_grant  <= SRC_W'(NUM_SRC - 1);
    end else if (gnt_valid) begin
      out_valid_o <= 1'b1;
      out_data_o  <= slot_data[gnt_idx];
      out_src_o   <= gnt_idx;
      last_grant  <= gnt_idx;
    end else if (free) begin
      out_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_o   <= '0;
      drop_count_o <= '0;
    end else begin
      overflow_o   <= (clear_i ? '0 : overflow_o) | drop;
      drop_count_o <= cnt_nxt;
    end
  end

endmodule
